// File: rtl/slice_fault_detector_pkg.sv
// Shared types and constants for the slice fault detector.
package slice_fault_detector_pkg;

    typedef enum logic [2:0] {IDLE, P0, C0, P1, C1, DONE} state_t;

    typedef enum logic [1:0] {V_OK, V_SA0, V_SA1, V_OTHER} verdict_t;

    localparam logic [3:0] W_ZERO = 4'h0;
    localparam logic [3:0] W_FULL = 4'hF;

    localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/sfd_cell_classify.sv
// Combinational per-cell verdict update for one capture phase (0: zero-weight pass, 1: full-weight pass).
module sfd_cell_classify
    import slice_fault_detector_pkg::*;
(
    input  logic [3:0] product,
    input  logic       phase,
    input  logic       prior_sa1,
    input  logic       prior_other,
    output logic       sa0,
    output logic       sa1,
    output logic       other
);

    verdict_t prior_v;
    verdict_t v;

    always_comb begin
        prior_v = prior_other ? V_OTHER : (prior_sa1 ? V_SA1 : V_OK);
        v       = prior_v;
        if (product == W_FULL) begin
            if (!phase && prior_v == V_OK) begin
                v = V_SA1;
            end
        end else if (product == W_ZERO) begin
            // A zero on the full pass only means stuck-at-0 for a cell that looked clean so far
            if (phase) begin
                v = (prior_v == V_OK) ? V_SA0 : V_OTHER;
            end
        end else begin
            v = V_OTHER;
        end
        sa0   = (v == V_SA0);
        sa1   = (v == V_SA1);
        other = (v == V_OTHER);
    end

endmodule

// File: rtl/slice_fault_detector.sv
// March-style test controller for the MAC slice: drives two patterns, classifies each cell.
// Optional SLICE_FAULT_DETECTOR_COUNT_EN adds a registered fault_count output.
module slice_fault_detector
    import slice_fault_detector_pkg::*;
#(
    parameter int unsigned N       = 256,
    parameter int unsigned MAC_LAT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [N-1:0]     in_array,
    output logic [4*N-1:0]   weight_array,
    input  logic [4*N-1:0]   product_array,
    output logic [N-1:0]     fault_sa0,
    output logic [N-1:0]     fault_sa1,
    output logic [N-1:0]     fault_other
`ifdef SLICE_FAULT_DETECTOR_COUNT_EN
    ,
    output logic [$clog2(N+1)-1:0] fault_count
`endif
);

    localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(MAC_LAT);

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   wait_cnt;
    logic [CNT_W-1:0]   wait_cnt_nxt;
    logic               busy_nxt;
    logic               done_nxt;
    logic [N-1:0]       in_nxt;
    logic [4*N-1:0]     weight_nxt;
    logic [N-1:0]       sa0_nxt;
    logic [N-1:0]       sa1_nxt;
    logic [N-1:0]       other_nxt;
    logic [N-1:0]       cls_sa0;
    logic [N-1:0]       cls_sa1;
    logic [N-1:0]       cls_other;
    logic               phase_c;

    assign phase_c = (state == C1);

    for (genvar i = 0; i < N; i++) begin : g_cell
        sfd_cell_classify u_cls (
            .product     (product_array[4*i +: 4]),
            .phase       (phase_c),
            .prior_sa1   (fault_sa1[i]),
            .prior_other (fault_other[i]),
            .sa0         (cls_sa0[i]),
            .sa1         (cls_sa1[i]),
            .other       (cls_other[i])
        );
    end

    // Next-state, wait counter, fault map update and registered-output next values
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        sa0_nxt      = fault_sa0;
        sa1_nxt      = fault_sa1;
        other_nxt    = fault_other;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt    = P0;
                    wait_cnt_nxt = '0;
                    sa0_nxt      = '0;
                    sa1_nxt      = '0;
                    other_nxt    = '0;
                end
            end
            P0, P1: begin
                if (wait_cnt == LAT_LAST) begin
                    state_nxt = (state == P0) ? C0 : C1;
                end else begin
                    wait_cnt_nxt = wait_cnt + CNT_W'(1);
                end
            end
            C0, C1: begin
                state_nxt    = (state == C0) ? P1 : DONE;
                wait_cnt_nxt = '0;
                sa0_nxt      = cls_sa0;
                sa1_nxt      = cls_sa1;
                other_nxt    = cls_other;
            end
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        busy_nxt   = (state_nxt != IDLE);
        done_nxt   = (state_nxt == DONE);
        in_nxt     = busy_nxt ? {N{1'b1}} : {N{1'b0}};
        weight_nxt = (state_nxt == P1 || state_nxt == C1 || state_nxt == DONE) ?
                     {N{W_FULL}} : {N{W_ZERO}};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            wait_cnt     <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            in_array     <= '0;
            weight_array <= '0;
            fault_sa0    <= '0;
            fault_sa1    <= '0;
            fault_other  <= '0;
        end else begin
            state        <= state_nxt;
            wait_cnt     <= wait_cnt_nxt;
            busy         <= busy_nxt;
            done         <= done_nxt;
            in_array     <= in_nxt;
            weight_array <= weight_nxt;
            fault_sa0    <= sa0_nxt;
            fault_sa1    <= sa1_nxt;
            fault_other  <= other_nxt;
        end
    end

`ifdef SLICE_FAULT_DETECTOR_COUNT_EN
    localparam int unsigned CW = $clog2(N+1);

    logic [CW-1:0] count_nxt;

    // Population count of the final verdicts, landing together with done
    always_comb begin
        count_nxt = fault_count;
        if (state == IDLE && start) begin
            count_nxt = '0;
        end else if (state == C1) begin
            count_nxt = '0;
            for (int i = 0; i < N; i++) begin
                count_nxt = count_nxt + CW'(cls_sa0[i] | cls_sa1[i] | cls_other[i]);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fault_count <= '0;
        end else begin
            fault_count <= count_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_slice_fault_detector.sv
// Directed bench: three detector instances (MAC_LAT 1, 3, 0) against a behavioural stuck-cell slice model.
module tb_slice_fault_detector;

    localparam int unsigned N = 16;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic [N-1:0] sa0_cells, sa1_cells, frc_cells;

    logic busy_a, done_a, busy_b, done_b, busy_z, done_z;
    logic [N-1:0]   in_a, in_b, in_z;
    logic [4*N-1:0] w_a, w_b, w_z, prod_a, prod_b, prod_z;
    logic [4*N-1:0] raw_a, raw_b;
    logic [4*N-1:0] pipe_b [3];
    logic [N-1:0]   s0_a, s1_a, ot_a, s0_b, s1_b, ot_b, s0_z, s1_z, ot_z;
`ifdef SLICE_FAULT_DETECTOR_COUNT_EN
    logic [$clog2(N+1)-1:0] cnt_a, cnt_b, cnt_z;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Slice model: SA1 overrides SA0; forced cells return 4'h6; healthy cells return in ? weight : 0
    function automatic logic [4*N-1:0] slice_model(input logic [N-1:0] in_v, input logic [4*N-1:0] w_v,
                                                   input logic [N-1:0] s0, input logic [N-1:0] s1,
                                                   input logic [N-1:0] fr);
        logic [4*N-1:0] p;
        p = '0;
        for (int i = 0; i < N; i++) begin
            if (s1[i])        p[4*i +: 4] = 4'hF;
            else if (s0[i])   p[4*i +: 4] = 4'h0;
            else if (fr[i])   p[4*i +: 4] = 4'h6;
            else if (in_v[i]) p[4*i +: 4] = w_v[4*i +: 4];
        end
        return p;
    endfunction

    assign raw_a  = slice_model(in_a, w_a, sa0_cells, sa1_cells, frc_cells);
    assign raw_b  = slice_model(in_b, w_b, sa0_cells, sa1_cells, frc_cells);
    assign prod_z = slice_model(in_z, w_z, sa0_cells, sa1_cells, frc_cells);
    assign prod_b = pipe_b[2];

    always @(posedge clk) begin
        prod_a    <= raw_a;
        pipe_b[0] <= raw_b;
        pipe_b[1] <= pipe_b[0];
        pipe_b[2] <= pipe_b[1];
    end

    slice_fault_detector #(.N(N), .MAC_LAT(1)) u_a (
        .clk(clk), .rst(rst), .start(start), .busy(busy_a), .done(done_a),
        .in_array(in_a), .weight_array(w_a), .product_array(prod_a),
        .fault_sa0(s0_a), .fault_sa1(s1_a), .fault_other(ot_a)
`ifdef SLICE_FAULT_DETECTOR_COUNT_EN
        , .fault_count(cnt_a)
`endif
    );

    slice_fault_detector #(.N(N), .MAC_LAT(3)) u_b (
        .clk(clk), .rst(rst), .start(start), .busy(busy_b), .done(done_b),
        .in_array(in_b), .weight_array(w_b), .product_array(prod_b),
        .fault_sa0(s0_b), .fault_sa1(s1_b), .fault_other(ot_b)
`ifdef SLICE_FAULT_DETECTOR_COUNT_EN
        , .fault_count(cnt_b)
`endif
    );

    slice_fault_detector #(.N(N), .MAC_LAT(0)) u_z (
        .clk(clk), .rst(rst), .start(start), .busy(busy_z), .done(done_z),
        .in_array(in_z), .weight_array(w_z), .product_array(prod_z),
        .fault_sa0(s0_z), .fault_sa1(s1_z), .fault_other(ot_z)
`ifdef SLICE_FAULT_DETECTOR_COUNT_EN
        , .fault_count(cnt_z)
`endif
    );

    typedef struct {
        logic [N-1:0] sa0;
        logic [N-1:0] sa1;
        logic [N-1:0] frc;
        logic [N-1:0] e_sa0;
        logic [N-1:0] e_sa1;
        logic [N-1:0] e_oth;
        int           extra_start;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic check_maps(input string tag, input logic [N-1:0] s0, input logic [N-1:0] s1,
                              input logic [N-1:0] ot, input vec_t v);
        check({tag, "_sa0"}, 64'(s0), 64'(v.e_sa0));
        check({tag, "_sa1"}, 64'(s1), 64'(v.e_sa1));
        check({tag, "_other"}, 64'(ot), 64'(v.e_oth));
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int n_a, n_b, n_z;
        n_a = 0; n_b = 0; n_z = 0;
        sa0_cells = v.sa0;
        sa1_cells = v.sa1;
        frc_cells = v.frc;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        for (int cyc = 1; cyc <= 20; cyc++) begin
            start = (cyc == v.extra_start);
            if (cyc == 1) begin
                check($sformatf("v%0d_busy_p0", idx), 64'(busy_a), 64'd1);
                check($sformatf("v%0d_in_p0", idx), 64'(in_a), 64'(16'hFFFF));
                check($sformatf("v%0d_w_p0", idx), w_a, 64'd0);
            end
            if (cyc == 4) check($sformatf("v%0d_w_p1", idx), w_a, 64'hFFFF_FFFF_FFFF_FFFF);
            if (done_a) begin
                n_a++;
                check($sformatf("v%0d_a_done_cyc", idx), 64'(cyc), 64'd7);
                check($sformatf("v%0d_a_busy_done", idx), 64'(busy_a), 64'd1);
                check_maps($sformatf("v%0d_a", idx), s0_a, s1_a, ot_a, v);
`ifdef SLICE_FAULT_DETECTOR_COUNT_EN
                check($sformatf("v%0d_a_count", idx), 64'(cnt_a), 64'($countones(v.e_sa0 | v.e_sa1 | v.e_oth)));
`endif
            end
            if (done_b) begin
                n_b++;
                check($sformatf("v%0d_b_done_cyc", idx), 64'(cyc), 64'd11);
                check_maps($sformatf("v%0d_b", idx), s0_b, s1_b, ot_b, v);
            end
            if (done_z) begin
                n_z++;
                check($sformatf("v%0d_z_done_cyc", idx), 64'(cyc), 64'd5);
                check_maps($sformatf("v%0d_z", idx), s0_z, s1_z, ot_z, v);
`ifdef SLICE_FAULT_DETECTOR_COUNT_EN
                check($sformatf("v%0d_z_count", idx), 64'(cnt_z), 64'($countones(v.e_sa0 | v.e_sa1 | v.e_oth)));
`endif
            end
            @(negedge clk);
        end
        start = 1'b0;
        check($sformatf("v%0d_a_done_pulses", idx), 64'(n_a), 64'd1);
        check($sformatf("v%0d_b_done_pulses", idx), 64'(n_b), 64'd1);
        check($sformatf("v%0d_z_done_pulses", idx), 64'(n_z), 64'd1);
        check($sformatf("v%0d_idle_busy", idx), {61'd0, busy_a, busy_b, busy_z}, 64'd0);
        check($sformatf("v%0d_idle_in", idx), 64'(in_a), 64'd0);
        // Maps hold after the run
        check_maps($sformatf("v%0d_a_hold", idx), s0_a, s1_a, ot_a, v);
    endtask

    initial begin
        int n_done;
        rst = 1'b1;
        start = 1'b0;
        sa0_cells = '0;
        sa1_cells = '0;
        frc_cells = '0;

        //             sa0       sa1       frc       e_sa0     e_sa1     e_oth    extra
        vecs[0] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0};
        vecs[1] = '{16'h0008, 16'h8001, 16'h0000, 16'h0008, 16'h8001, 16'h0000, 0};
        vecs[2] = '{16'h0080, 16'h0080, 16'h0000, 16'h0000, 16'h0080, 16'h0000, 0};
        vecs[3] = '{16'h0000, 16'h0000, 16'h0020, 16'h0000, 16'h0000, 16'h0020, 0};
        vecs[4] = '{16'h0000, 16'h0400, 16'h0000, 16'h0000, 16'h0400, 16'h0000, 2};
        vecs[5] = '{16'h0003, 16'h0300, 16'h1000, 16'h0003, 16'h0300, 16'h1000, 5};

        repeat (2) @(negedge clk);
        check("rst_busy_done", {60'd0, busy_a, done_a, busy_z, done_z}, 64'd0);
        check("rst_in", 64'(in_a), 64'd0);
        check("rst_w", w_a, 64'd0);
        check("rst_maps", 64'(s0_a | s1_a | ot_a), 64'd0);
`ifdef SLICE_FAULT_DETECTOR_COUNT_EN
        check("rst_count", 64'(cnt_a), 64'd0);
`endif
        rst = 1'b0;
        @(negedge clk);
        check("idle_no_start_busy", 64'(busy_a), 64'd0);

        for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

        // Reset while u_a is in C0 (u_z already holds captured maps at this point)
        sa0_cells = 16'h0008;
        sa1_cells = 16'h8001;
        frc_cells = 16'h0000;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("mid_in_before_rst", 64'(in_a), 64'(16'hFFFF));
        check("mid_z_sa1_before_rst", 64'(s1_z), 64'(16'h8001));
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_busy", {61'd0, busy_a, busy_b, busy_z}, 64'd0);
        check("mid_rst_patterns", 64'(in_a | in_b | in_z), 64'd0);
        check("mid_rst_weights", w_a | w_b | w_z, 64'd0);
        check("mid_rst_maps", 64'(s0_a | s1_a | ot_a | s0_z | s1_z | ot_z), 64'd0);
        rst = 1'b0;
        n_done = 0;
        for (int c = 0; c < 15; c++) begin
            if (done_a || done_b || done_z) n_done++;
            @(negedge clk);
        end
        check("mid_rst_no_done", 64'(n_done), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
